// File: rtl/bpred_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
package bpred_pkg;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bpred_cnt_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bpred_state_t;

  // Value every counter holds after the initialisation walk.
  localparam bpred_cnt_t CNT_INIT = WNT;

  // BTB entry layout for the default geometry (XLEN 32, 64 entries).
  // btb_array derives the same layout from its own parameters.
  localparam int unsigned BTB_DEF_XLEN  = 32;
  localparam int unsigned BTB_DEF_TAG_W = BTB_DEF_XLEN - 6 - 2;

  typedef struct packed {
    logic                     valid;
    logic [BTB_DEF_TAG_W-1:0] tag;
    logic [BTB_DEF_XLEN-1:0]  target;
  } btb_entry_t;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic bpred_cnt_t cnt_next(input bpred_cnt_t cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : bpred_cnt_t'(cnt + 2'd1);
    end
    return (cnt == SNT) ? SNT : bpred_cnt_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: registered read, one training write
// port, an initialisation clear port, and the tag compare on the read data.
module btb_array #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned XLEN    = 32
) (
  input  logic                       clk_i,
  input  logic [XLEN-1:0]            rd_pc_i,
  input  logic                       clr_en_i,
  input  logic [$clog2(ENTRIES)-1:0] clr_idx_i,
  input  logic                       wr_en_i,
  input  logic [XLEN-1:0]            wr_pc_i,
  input  logic [XLEN-1:0]            wr_target_i,
  output logic                       hit_o,
  output logic [XLEN-1:0]            target_o
);
  import bpred_pkg::*;

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t            mem_q [ENTRIES];
  entry_t            rd_entry_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  entry_t            wr_entry;

  // Instruction-aligned PCs: the two low bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_idx          = rd_pc_i[IDX_W+1:2];
  assign wr_idx          = wr_pc_i[IDX_W+1:2];
  assign wr_entry.valid  = 1'b1;
  assign wr_entry.tag    = wr_pc_i[XLEN-1:IDX_W+2];
  assign wr_entry.target = wr_target_i;

  // Registered read of the lookup slot (old contents on a same-cycle write),
  // plus the clear/train write; the clear walk and training never overlap.
  always_ff @(posedge clk_i) begin
    rd_entry_q <= mem_q[rd_idx];
    rd_tag_q   <= rd_pc_i[XLEN-1:IDX_W+2];
    if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign hit_o    = rd_entry_q.valid && (rd_entry_q.tag == rd_tag_q);
  assign target_o = rd_entry_q.target;

endmodule

// File: rtl/bimodal_branch_predictor.sv
// Bimodal predictor top: init FSM, PHT of 2-bit counters, BTB instance,
// registered prediction response and the branch-tracker event port.
module bimodal_branch_predictor
  import bpred_pkg::*;
#(
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned XLEN        = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_predictor,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_prediction,
  input  logic            branch_result,
  input  logic [XLEN-1:0] branch_target,
  output logic            init_busy,
  output logic            trk_update,
  output logic            trk_prediction,
  output logic            trk_branch_result
);

  localparam int unsigned PHT_W  = $clog2(PHT_ENTRIES);
  localparam int unsigned BTB_W  = $clog2(BTB_ENTRIES);
  localparam int unsigned WALK_N = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
  localparam int unsigned IDX_W  = $clog2(WALK_N);

  bpred_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W:0]    idx_ext;
  logic              walking, pht_init_we, btb_init_we, upd_en;

  bpred_cnt_t        pht_q [PHT_ENTRIES];
  bpred_cnt_t        pht_rd_q;
  logic [PHT_W-1:0]  fetch_pht_idx, upd_pht_idx;

  logic              pred_valid_q;
  logic [XLEN-1:0]   pc_plus4_q;
  logic              btb_hit;
  logic [XLEN-1:0]   btb_target;

  logic              trk_update_q, trk_prediction_q, trk_branch_result_q;

  assign walking       = (state_q == INIT);
  assign idx_ext       = {1'b0, idx_q};
  assign pht_init_we   = walking && (idx_ext < (IDX_W+1)'(PHT_ENTRIES));
  assign btb_init_we   = walking && (idx_ext < (IDX_W+1)'(BTB_ENTRIES));
  assign upd_en        = update_predictor && (state_q == READY);
  assign fetch_pht_idx = fetch_pc[PHT_W+1:2];
  assign upd_pht_idx   = update_pc[PHT_W+1:2];

  // Next-state logic: step the walk index and leave INIT after the last write.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WALK_N - 1)) begin
          state_d = READY;
          idx_d   = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // State register; reset (re)starts the walk from index 0.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (RST) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // PHT: registered lookup read (pre-update value on a collision), then the
  // walk write or a saturating read-modify-write training update.
  always_ff @(posedge CLK) begin
    // NOTE: the table has no reset term; the walk initialises it, which keeps
    // it a plain RAM rather than hundreds of resettable flops.
    pht_rd_q <= pht_q[fetch_pht_idx];
    if (pht_init_we) begin
      pht_q[idx_q[PHT_W-1:0]] <= CNT_INIT;
    end else if (upd_en) begin
      pht_q[upd_pht_idx] <= cnt_next(pht_q[upd_pht_idx], branch_result);
    end
  end

  btb_array #(
    .ENTRIES (BTB_ENTRIES),
    .XLEN    (XLEN)
  ) u_btb (
    .clk_i       (CLK),
    .rd_pc_i     (fetch_pc),
    .clr_en_i    (btb_init_we),
    .clr_idx_i   (idx_q[BTB_W-1:0]),
    .wr_en_i     (upd_en && branch_result),
    .wr_pc_i     (update_pc),
    .wr_target_i (branch_target),
    .hit_o       (btb_hit),
    .target_o    (btb_target)
  );

  // Response qualifier and fall-through PC, registered alongside the table reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pred_valid_q <= 1'b0;
      pc_plus4_q   <= '0;
    end else begin
      pred_valid_q <= fetch_valid && (state_q == READY);
      pc_plus4_q   <= fetch_pc + XLEN'(4);
    end
  end

  // Tracker event: a one-cycle delayed copy of each accepted update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      trk_update_q        <= 1'b0;
      trk_prediction_q    <= 1'b0;
      trk_branch_result_q <= 1'b0;
    end else begin
      trk_update_q        <= upd_en;
      trk_prediction_q    <= upd_en && update_prediction;
      trk_branch_result_q <= upd_en && branch_result;
    end
  end

  assign pred_valid        = pred_valid_q;
  assign pred_taken        = pred_valid_q && pht_rd_q[1] && btb_hit;
  assign pred_target       = pred_taken   ? btb_target :
                             pred_valid_q ? pc_plus4_q : '0;
  assign init_busy         = walking;
  assign trk_update        = trk_update_q;
  assign trk_prediction    = trk_prediction_q;
  assign trk_branch_result = trk_branch_result_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Scoreboard bench for the bimodal predictor: stimulus pushes expected
// responses, two monitors pop and compare whenever the DUT presents one.
module tb_bimodal_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        update_predictor;
  logic [31:0] update_pc;
  logic        update_prediction, branch_result;
  logic [31:0] branch_target;
  logic        init_busy, trk_update, trk_prediction, trk_branch_result;

  bimodal_branch_predictor #(
    .PHT_ENTRIES (256),
    .BTB_ENTRIES (64),
    .XLEN        (32)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .pred_valid        (pred_valid),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .update_predictor  (update_predictor),
    .update_pc         (update_pc),
    .update_prediction (update_prediction),
    .branch_result     (branch_result),
    .branch_target     (branch_target),
    .init_busy         (init_busy),
    .trk_update        (trk_update),
    .trk_prediction    (trk_prediction),
    .trk_branch_result (trk_branch_result)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } pred_exp_t;

  typedef struct {
    logic pred;
    logic res;
  } trk_exp_t;

  pred_exp_t pred_q[$];
  trk_exp_t  trk_q[$];
  pred_exp_t mon_p;
  trk_exp_t  mon_t;
  int        n_vec = 0;
  int        n_err = 0;
  int        walk_n, walk_trk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Prediction monitor.
  always @(negedge CLK) begin
    if (pred_valid === 1'b1) begin
      if (pred_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected pred_valid: got 1, want 0 (pc response 0x%08h)", pred_target);
      end else begin
        mon_p = pred_q.pop_front();
        check("pred_taken", {31'd0, pred_taken}, {31'd0, mon_p.taken});
        check("pred_target", pred_target, mon_p.target);
      end
    end
  end

  // Tracker monitor.
  always @(negedge CLK) begin
    if (trk_update === 1'b1) begin
      if (trk_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected trk_update: got 1, want 0");
      end else begin
        mon_t = trk_q.pop_front();
        check("trk_prediction", {31'd0, trk_prediction}, {31'd0, mon_t.pred});
        check("trk_branch_result", {31'd0, trk_branch_result}, {31'd0, mon_t.res});
      end
    end
  end

  task automatic step(input logic fv, input logic [31:0] fpc, input logic et, input logic [31:0] etgt,
                      input logic up, input logic [31:0] upc, input logic upred, input logic res,
                      input logic [31:0] btgt);
    pred_exp_t p;
    trk_exp_t  t;
    @(posedge CLK);
    #1;
    fetch_valid       = fv;
    fetch_pc          = fpc;
    update_predictor  = up;
    update_pc         = upc;
    update_prediction = upred;
    branch_result     = res;
    branch_target     = btgt;
    if (fv) begin
      p.taken  = et;
      p.target = etgt;
      pred_q.push_back(p);
    end
    if (up) begin
      t.pred = upred;
      t.res  = res;
      trk_q.push_back(t);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    step(1'b1, pc, et, etgt, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic pred, input logic res, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, pred, res, tgt);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Counts negedges with init_busy high, starting at the current negedge.
  task automatic walk(output int n, output int trk_seen);
    n = 0;
    trk_seen = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      if (trk_update === 1'b1) trk_seen++;
      @(negedge CLK);
    end
    fetch_valid      = 1'b0;
    update_predictor = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " init_busy"}, {31'd0, init_busy}, 32'd1);
    check({tag, " pred_valid"}, {31'd0, pred_valid}, 32'd0);
    check({tag, " pred_taken"}, {31'd0, pred_taken}, 32'd0);
    check({tag, " pred_target"}, pred_target, 32'd0);
    check({tag, " trk_update"}, {31'd0, trk_update}, 32'd0);
    check({tag, " trk_prediction"}, {31'd0, trk_prediction}, 32'd0);
    check({tag, " trk_branch_result"}, {31'd0, trk_branch_result}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lookups and updates stay asserted through reset and the walk; all must be ignored.
    RST               = 1'b1;
    fetch_valid       = 1'b1;
    fetch_pc          = 32'h100;
    update_predictor  = 1'b1;
    update_pc         = 32'h200;
    update_prediction = 1'b1;
    branch_result     = 1'b1;
    branch_target     = 32'h80;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("reset");
    walk(walk_n, walk_trk);
    check("walk length", walk_n, 32'd256);
    check("trk_update during walk", walk_trk, 32'd0);

    // Cold lookup: WNT, BTB empty.
    look(32'h100, 1'b0, 32'h104);

    // Training WNT -> WT -> ST, then back down to WNT.
    upd(32'h200, 1'b0, 1'b1, 32'h80);
    upd(32'h200, 1'b1, 1'b1, 32'h80);
    look(32'h200, 1'b1, 32'h80);
    upd(32'h200, 1'b1, 1'b0, 32'h80);
    upd(32'h200, 1'b1, 1'b0, 32'h80);
    look(32'h200, 1'b0, 32'h204);

    // Saturate high: five taken leave ST, one not-taken gives WT (still taken).
    repeat (5) upd(32'h200, 1'b0, 1'b1, 32'h80);
    upd(32'h200, 1'b1, 1'b0, 32'h80);
    look(32'h200, 1'b1, 32'h80);

    // BTB alias: 0x300 shares BTB slot 0 with 0x200 and evicts it.
    upd(32'h200, 1'b1, 1'b1, 32'h80);
    upd(32'h300, 1'b0, 1'b1, 32'h500);
    look(32'h200, 1'b0, 32'h204);
    look(32'h300, 1'b1, 32'h500);

    // Saturate low from WNT: six not-taken stay at SNT, one taken gives WNT.
    repeat (6) upd(32'h400, 1'b0, 1'b0, 32'h40);
    upd(32'h400, 1'b0, 1'b1, 32'h40);
    look(32'h400, 1'b0, 32'h404);

    // Same-cycle lookup and taken update: lookup sees pre-update state.
    step(1'b1, 32'h204, 1'b0, 32'h208, 1'b1, 32'h204, 1'b0, 1'b1, 32'h900);
    look(32'h204, 1'b1, 32'h900);

    // Fall-through wraps at the top of the address space.
    look(32'hFFFF_FFFC, 1'b0, 32'h0);

    // Tracker: predicted taken, actually not taken.
    upd(32'h208, 1'b1, 1'b0, 32'h0);

    // Mid-operation reset with lookup and update both active.
    step(1'b1, 32'h204, 1'b1, 32'h900, 1'b1, 32'h204, 1'b1, 1'b1, 32'h900);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST              = 1'b0;
    fetch_valid      = 1'b0;
    update_predictor = 1'b0;
    @(negedge CLK);
    check_reset_outputs("mid-op reset");
    walk(walk_n, walk_trk);
    check("rewalk length", walk_n, 32'd256);
    look(32'h204, 1'b0, 32'h208);
    idle();

    repeat (4) @(negedge CLK);
    check("pred responses outstanding", pred_q.size(), 32'd0);
    check("trk events outstanding", trk_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
